// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score display path.
package score_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd2_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } score_state_e;

    // Two-digit BCD increment; 99 saturates rather than wrapping to an illegal tens digit.
    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.tens == 4'd9 && v.units == 4'd9) begin
            r = v;
        end else if (v.units == 4'd9) begin
            r.units = 4'd0;
            r.tens  = v.tens + 4'd1;
        end else begin
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_bcd_counter_if.sv
// Score counter bus: game-logic inputs, video digit select, and the SN7448-facing outputs.
interface score_bcd_counter_if;
    import score_pkg::*;

    logic  clr;
    logic  enable;
    logic  score_in;
    logic  digit_sel;
    bcd_t  bcd;
    logic  rbi_n;
    bcd2_t score;
    logic  win;
    logic  busy;

    // Game/video side
    modport master (
        output clr, enable, score_in, digit_sel,
        input  bcd, rbi_n, score, win, busy
    );

    // Counter side
    modport slave (
        input  clr, enable, score_in, digit_sel,
        output bcd, rbi_n, score, win, busy
    );

endinterface

// File: rtl/bcd_digit_mux.sv
// Selects the tens or units nibble for a time-shared SN7448 and drives its
// ripple-blanking input so a leading-zero tens digit can be suppressed.
module bcd_digit_mux
    import score_pkg::*;
#(
    parameter logic BLANK_LEAD = 1'b1
) (
    input  bcd2_t value_i,
    input  logic  digit_sel_i,
    output bcd_t  bcd_o,
    output logic  rbi_n_o
);

    assign bcd_o   = digit_sel_i ? value_i.tens : value_i.units;
    // Only the tens digit is ever blanked; a units zero is always shown.
    assign rbi_n_o = ~(BLANK_LEAD & digit_sel_i & (value_i.tens == 4'd0));

endmodule

// File: rtl/score_bcd_counter.sv
// Two-digit BCD score counter for one player: rising-edge event detect,
// holdoff after each accepted event, freeze at WIN_SCORE, and a digit mux
// feeding a shared SN7448 decoder.
module score_bcd_counter
    import score_pkg::*;
#(
    parameter logic [7:0] WIN_SCORE  = 8'h99,
    parameter int         HOLDOFF    = 16,
    parameter logic       BLANK_LEAD = 1'b1
) (
    input logic               clk_sys,
    input logic               reset,
    score_bcd_counter_if.slave bus
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

    logic             s_q;
    score_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bcd2_t            score_q, score_d;
    logic             win_q, win_d;
    logic             evt;
    bcd2_t            score_inc;

    assign evt       = bus.score_in & ~s_q;
    assign score_inc = bcd2_inc(score_q);

    // Next-state logic: accept an event only when idle, enabled and not yet won.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (evt && bus.enable && !win_q) begin
                    score_d = score_inc;
                    win_d   = (score_inc == bcd2_t'(WIN_SCORE));
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Events are ignored here; enable dropping does not cut the holdoff short.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; clr behaves exactly like reset and wins over a same-cycle event.
    always_ff @(posedge clk_sys) begin
        if (reset || bus.clr) begin
            s_q     <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            score_q <= '0;
            win_q   <= 1'b0;
        end else begin
            s_q     <= bus.score_in;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            win_q   <= win_d;
        end
    end

    assign bus.score = score_q;
    assign bus.win   = win_q;
    assign bus.busy  = (state_q == HOLD);

    bcd_digit_mux #(
        .BLANK_LEAD (BLANK_LEAD)
    ) u_digit_mux (
        .value_i     (score_q),
        .digit_sel_i (bus.digit_sel),
        .bcd_o       (bus.bcd),
        .rbi_n_o     (bus.rbi_n)
    );

    a_bcd_digits_legal: assert property (@(posedge clk_sys) disable iff (reset)
        (score_q.tens <= 4'd9) && (score_q.units <= 4'd9));

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Two-digit BCD score counter for one player, directly upstream of the SN7448 seven-segment decoder in the score display path.
- Counts qualified score pulses from game logic and freezes at a parameterised winning score.
- Presents one BCD nibble at a time (tens or units, chosen by the video digit-select) plus a ripple-blanking signal, so a single SN7448 instance can be time-shared per player.

Parameters:
- WIN_SCORE, 8'h99, packed BCD score at which counting stops and `win` asserts; legal range 8'h01..8'h99.
- HOLDOFF, 16, clock cycles after an accepted pulse during which further pulses are ignored; must be >= 1.
- BLANK_LEAD, 1'b1, 1 = blank a leading-zero tens digit via `rbi_n`; 0 = always show the tens digit.

Ports:
- clk_sys  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clr  input  1  synchronous score clear (new game), same effect as reset on all state
- enable  input  1  scoring allowed (attract mode = 0)
- score_in  input  1  score event level from game logic, synchronous to clk_sys; the rising edge is the event
- digit_sel  input  1  0 = units nibble, 1 = tens nibble on `bcd`
- bcd  output  4  {D,C,B,A} nibble to SN7448
- rbi_n  output  1  ripple-blanking input for SN7448; 0 requests blanking of a zero digit
- score  output  8  packed BCD {tens,units}
- win  output  1  score == WIN_SCORE
- busy  output  1  holdoff active

Behaviour:
- Reset and clr:
  - Both are synchronous, one cycle.
  - score=8'h00, win=0, busy=0, FSM=IDLE, edge register=0.
  - A reset or clr asserted mid-holdoff aborts the holdoff.
  - clr has priority over a simultaneous event.
- Edge detect:
  - Register `score_in` as s_q (reset value 0).
  - evt = score_in & ~s_q.
  - A level held high counts exactly once.
- FSM states:
  - IDLE:
    - If evt & enable & ~win: increment the score next cycle, load the holdoff counter with HOLDOFF-1, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD:
    - busy=1. The counter decrements each cycle, and evt is ignored.
    - When the counter reaches 0, return to IDLE, so busy is high for exactly HOLDOFF cycles.
    - enable going low does not abort the holdoff.
- Increment arithmetic (BCD):
  - If units==9: units=0 and tens=tens+1; otherwise units=units+1.
  - Tens 9 with units 9 cannot be exceeded, because win blocks increments when WIN_SCORE=8'h99.
- Timing: `score` updates on the clock edge after the one where evt is sampled, i.e. one cycle of latency from score_in rising (seen by the edge detector) to the new score.
- Win:
  - win is registered and goes 1 in the same cycle `score` becomes WIN_SCORE.
  - win stays 1 until reset or clr; further events are ignored.
- Display mux (combinational from registered score):
  - bcd = digit_sel ? tens : units.
  - rbi_n = ~(BLANK_LEAD & digit_sel & (tens==0)).
  - When digit_sel=0, rbi_n is always 1, so a units 0 is displayed.
- Tens/units nibbles are never outside 0..9 (invariant, checked by assertion).

Decomposition:
- Shared package `score_pkg`:
  - typedef `bcd_t` (logic [3:0]) and `bcd2_t` (struct {bcd_t tens; bcd_t units;}).
  - FSM enum `score_state_e` {IDLE, HOLD}.
  - function `bcd2_inc(bcd2_t)`.
- Sub-module `bcd_digit_mux`: the digit_sel/rbi_n selection logic.
  - Reused by the other player's counter and by the timer display.
- Counter, holdoff and FSM stay in the top module.

Test Plan:
- Reset/clr → score=00, win=0, busy=0. With digit_sel=1: bcd=0, rbi_n=0. With digit_sel=0: bcd=0, rbi_n=1.
- Single pulse (score_in high 1 cycle, enable=1) → score=01 one cycle after the edge. busy high for exactly 16 cycles. A second pulse at cycle +5 is ignored and score stays 01.
- Carry: preload to 09 via 9 spaced pulses, then one more → score=8'h10. digit_sel=1 gives bcd=1, rbi_n=1. Held score_in level (100 cycles high) increments only once.
- Win: WIN_SCORE=8'h15, drive 20 spaced pulses → score freezes at 15, win=1 on the 15th increment, later pulses produce no busy.
- enable=0 with pulses → no change. clr asserted in the same cycle as an evt during HOLD → score=00, busy=0 next cycle, and the evt is not counted.
- BLANK_LEAD=0, score=07, digit_sel=1 → bcd=0, rbi_n=1 (leading zero shown).
